mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF) and the load/store unit (DM), with one outstanding transaction at a time.
- DM has priority by default; a starvation guard forces an IF grant after a configurable run of DM grants.
- Sits between the fetch/LSU stage logic and the unified memory, and lets the core run from one memory.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits wide
- STARVE_LIMIT, 4, consecutive DM grants allowed while IF waits; must be >= 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, held until if_ready
if_addr  in  ADDR_W  fetch address
if_ready  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch data valid, 1-cycle pulse
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request, held until dm_ready
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_be  in  DATA_W/8  byte enables
dm_ready  out  1  data request accepted this cycle
dm_rvalid  out  1  load data or store ack, 1-cycle pulse
dm_rdata  out  DATA_W  load data; must be 0 on store ack
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  write enable
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_be  out  DATA_W/8  byte enables; all-ones for fetch
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  response valid; every request gets exactly one response, including writes
mem_rdata  in  DATA_W  response data
busy  out  1  state != IDLE
owner  out  1  0 = IF, 1 = DM; valid while busy
proto_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - All outputs 0, including the mem_* registers, owner and proto_err.
  - Streak counter cleared.
  - Any in-flight transaction is abandoned.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - With no request pending, stay in IDLE.
  - Otherwise select a winner:
    - DM if dm_req and (!if_req or streak < STARVE_LIMIT);
    - else IF.
  - In the same cycle, pulse the winner's ready combinationally.
  - Register addr, we, wdata and be into the mem_* outputs and set owner.
  - Next state ISSUE.
  - For IF: mem_we = 0, mem_wdata = 0, mem_be = all-ones.
- ISSUE:
  - mem_req = 1; mem_* outputs stay stable.
  - On mem_gnt, go to WAIT; mem_req is 0 from the next cycle.
- WAIT:
  - On mem_rvalid, pulse the owner's rvalid in the same cycle (combinational).
  - Owner's rdata = mem_rdata for IF and for DM loads; 0 for DM stores.
  - Next state IDLE.
  - The non-owner's rvalid stays 0.
- Outside a response cycle, if_rdata and dm_rdata must be 0.
- Throughput and latency:
  - Minimum transaction is 3 cycles (accept, ISSUE with immediate gnt, WAIT with immediate rvalid).
  - A new request is accepted in the first IDLE cycle, i.e. the cycle after rvalid.
  - No back-to-back overlap.
- Streak counter, width clog2(STARVE_LIMIT+1), updated on each grant:
  - DM grant while if_req = 1: increment, saturating at STARVE_LIMIT.
  - DM grant while if_req = 0: clear to 0.
  - IF grant: clear to 0.
- proto_err is set (sticky until reset) on:
  - mem_rvalid in IDLE or ISSUE, including stale responses arriving after a mid-transaction reset;
  - mem_gnt outside ISSUE.
  - The stray event is otherwise ignored: no rvalid is forwarded.
- mem_gnt and mem_rvalid in the same cycle while in ISSUE: gnt is honoured, rvalid counts as an error (proto_err = 1). Memory must return rvalid at least 1 cycle after gnt.
- Requesters may drop req only after ready. Arbiter behaviour on a withdrawn req is undefined; the bench does not exercise it.

Test Plan:
1. Single fetch: if_req, if_addr = 0x100; mem_gnt on the first ISSUE cycle; mem_rvalid 2 cycles later with mem_rdata = 0x00A00093 -> if_ready pulses at cycle 0, mem_req high for 1 cycle with mem_addr = 0x100 and mem_be = 0xF, if_rvalid pulses with if_rdata = 0x00A00093, busy returns to 0.
2. Store ack: dm_req, dm_we = 1, dm_addr = 0x2004, dm_wdata = 0xDEADBEEF, dm_be = 0x3 -> mem_we = 1, mem_be = 0x3, mem_wdata = 0xDEADBEEF; on rvalid, dm_rvalid = 1 with dm_rdata = 0.
3. Priority and starvation, STARVE_LIMIT = 4: if_req and dm_req held high continuously -> grant order DM, DM, DM, DM, IF, DM, ...; owner matches each grant.
4. mem_gnt held low 5 cycles -> mem_req stays high and mem_addr stable for all 6 ISSUE cycles; no ready pulses during the wait.
5. Reset mid-WAIT: assert rst_n low while in WAIT, release, then drive a stale mem_rvalid -> all outputs 0 after reset, no if_rvalid/dm_rvalid pulse, proto_err = 1.
6. Spurious response: mem_rvalid in IDLE -> proto_err = 1 and remains 1 through later normal transactions.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, DM-first with an IF starvation guard
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_ready,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                owner,
    output logic                proto_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t              r_state, w_next;
    logic                r_owner, r_we, r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;
    logic [SW-1:0]       r_streak;
    logic                w_idle, w_accept, w_dm_win, w_resp, w_stray;
    assign w_idle   = r_state == IDLE;
    assign w_accept = w_idle && (if_req || dm_req);
    assign w_dm_win = dm_req && (!if_req || r_streak < SW'(STARVE_LIMIT));
    assign w_resp   = r_state == WAIT && mem_rvalid;
    assign w_stray  = (mem_rvalid && r_state != WAIT) || (mem_gnt && r_state != ISSUE);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (if_req || dm_req) w_next = ISSUE;
            ISSUE:   if (mem_gnt) w_next = WAIT;
            WAIT:    if (mem_rvalid) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_be     <= '0;
            r_streak <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner  <= w_dm_win;
                r_we     <= w_dm_win && dm_we;
                r_addr   <= w_dm_win ? dm_addr : if_addr;
                r_wdata  <= w_dm_win ? dm_wdata : '0;
                r_be     <= w_dm_win ? dm_be : '1;
                r_streak <= !(w_dm_win && if_req) ? '0 :
                            r_streak == SW'(STARVE_LIMIT) ? r_streak : r_streak + 1'b1;
            end
            if (w_stray) r_err <= 1'b1;
        end
    end
    assign if_ready  = w_idle && if_req && !w_dm_win;
    assign dm_ready  = w_idle && w_dm_win;
    assign if_rvalid = w_resp && !r_owner;
    assign dm_rvalid = w_resp && r_owner;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = (dm_rvalid && !r_we) ? mem_rdata : '0;
    assign mem_req   = r_state == ISSUE;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign busy      = !w_idle;
    assign owner     = r_owner;
    assign proto_err = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction-level check of mem_port_arbiter against a grant/streak model
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_req, dm_we, mem_gnt, mem_rvalid;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_be;
    logic        if_ready, if_rvalid, dm_ready, dm_rvalid, mem_req, mem_we, busy, owner, proto_err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    int n_chk = 0, n_bad = 0;
    int streak = 0;
    bit if_pend = 0, dm_pend = 0, exp_err = 0, last_dm = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_if(input logic [31:0] a);
        if_req = 1; if_addr = a; if_pend = 1;
    endtask

    task automatic set_dm(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = wd; dm_be = be; dm_pend = 1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mreq"}, mem_req, 0);
        check({tag, "_mwe"}, mem_we, 0);
        check({tag, "_maddr"}, mem_addr, 0);
        check({tag, "_mwdata"}, mem_wdata, 0);
        check({tag, "_mbe"}, mem_be, 0);
        check({tag, "_owner"}, owner, 0);
        check({tag, "_err"}, proto_err, 0);
        check({tag, "_rv"}, {if_rvalid, dm_rvalid, if_ready, dm_ready}, 0);
        check({tag, "_rdata"}, {if_rdata, dm_rdata}, 0);
    endtask

    // Called at a negedge with the pending requests already driven; returns at the next IDLE negedge.
    task automatic run_txn(input int g, input int r, input logic [31:0] rd);
        bit w_dm, ewe;
        logic [31:0] ea, ewd;
        logic [3:0] ebe;
        w_dm = dm_pend && (!if_pend || streak < LIMIT);
        ewe  = w_dm && dm_we;
        ea   = w_dm ? dm_addr : if_addr;
        ewd  = w_dm ? dm_wdata : 32'h0;
        ebe  = w_dm ? dm_be : 4'hF;
        #1;
        check("if_ready", if_ready, !w_dm);
        check("dm_ready", dm_ready, w_dm);
        streak  = (w_dm && if_pend) ? ((streak < LIMIT) ? streak + 1 : LIMIT) : 0;
        last_dm = w_dm;
        @(negedge clk);
        if (w_dm) begin dm_req = 0; dm_pend = 0; end
        else begin if_req = 0; if_pend = 0; end
        for (int k = 0; k <= g; k++) begin
            mem_gnt = (k == g);
            #1;
            check("issue_mreq", mem_req, 1);
            check("issue_busy", busy, 1);
            check("issue_owner", owner, w_dm);
            check("issue_fields", {mem_we, mem_addr, mem_wdata, mem_be}, {ewe, ea, ewd, ebe});
            check("issue_ready", {if_ready, dm_ready}, 0);
            check("issue_rv", {if_rvalid, dm_rvalid}, 0);
            check("issue_err", proto_err, exp_err);
            @(negedge clk);
        end
        mem_gnt = 0;
        for (int k = 0; k <= r; k++) begin
            mem_rvalid = (k == r);
            mem_rdata  = (k == r) ? rd : $urandom;
            #1;
            check("wait_mreq", mem_req, 0);
            check("wait_busy", busy, 1);
            check("if_rvalid", if_rvalid, k == r && !w_dm);
            check("dm_rvalid", dm_rvalid, k == r && w_dm);
            check("if_rdata", if_rdata, (k == r && !w_dm) ? rd : 32'h0);
            check("dm_rdata", dm_rdata, (k == r && w_dm && !ewe) ? rd : 32'h0);
            check("wait_err", proto_err, exp_err);
            @(negedge clk);
        end
        mem_rvalid = 0;
        mem_rdata  = 0;
        #1;
        check("end_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0;
        dm_wdata = 0; dm_be = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        #1 check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        set_if(32'h100);
        run_txn(0, 1, 32'h00A00093);
        set_dm(1, 32'h2004, 32'hDEADBEEF, 4'h3);
        run_txn(0, 0, $urandom);
        for (int j = 0; j < 10; j++) begin
            if (!if_pend) set_if($urandom);
            if (!dm_pend) set_dm($urandom_range(0, 1), $urandom, $urandom, 4'($urandom));
            run_txn(0, 0, $urandom);
            check("starve_order", last_dm, (j % 5) != 4);
        end
        if (!if_pend) set_if(32'h4000);
        run_txn(5, 0, $urandom);
        for (int j = 0; j < 60; j++) begin
            if (!if_pend && $urandom_range(0, 1)) set_if($urandom);
            if (!dm_pend && $urandom_range(0, 1)) set_dm($urandom_range(0, 1), $urandom, $urandom, 4'($urandom));
            if (!if_pend && !dm_pend) set_dm(0, $urandom, $urandom, 4'($urandom));
            run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end
        while (if_pend || dm_pend) run_txn(0, 0, $urandom);
        mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
        #1 check("spur_rv", {if_rvalid, dm_rvalid}, 0);
        @(negedge clk);
        mem_rvalid = 0; exp_err = 1;
        #1 check("spur_err", proto_err, 1);
        for (int j = 0; j < 3; j++) begin
            if ($urandom_range(0, 1)) set_if($urandom);
            else set_dm($urandom_range(0, 1), $urandom, $urandom, 4'($urandom));
            run_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom);
        end
        check("spur_sticky", proto_err, 1);
        set_if(32'h300);
        #1 check("rst_accept", if_ready, 1);
        @(negedge clk);
        if_req = 0; if_pend = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        #1 check("rst_inwait", busy, 1);
        rst_n = 0;
        #1 check_idle_outputs("midrst");
        exp_err = 0; streak = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'h12345678;
        #1 check("stale_rv", {if_rvalid, dm_rvalid, if_rdata, dm_rdata}, 0);
        @(negedge clk);
        mem_rvalid = 0; exp_err = 1;
        #1 check("stale_err", proto_err, 1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1; exp_err = 0;
        #1 check("gnt_pre_err", proto_err, 0);
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0; exp_err = 1;
        #1 check("gnt_idle_err", proto_err, 1);
        set_dm(0, 32'h80, 32'h0, 4'hF);
        run_txn(1, 1, 32'hCAFEF00D);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
